// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - debug command encodings and frame helpers shared by the serial command decoder
package debug_pkg;

    typedef enum logic [3:0] {
        FN_NONE      = 4'd0,
        FN_PAUSE     = 4'd1,
        FN_RESUME    = 4'd2,
        FN_STEP      = 4'd3,
        FN_RESET     = 4'd4,
        FN_STATUS    = 4'd5,
        FN_BR_PT_ADD = 4'd6,
        FN_BR_PT_RM  = 4'd7,
        FN_MEM_RD    = 4'd8,
        FN_MEM_WR    = 4'd9,
        FN_REG_RD    = 4'd10,
        FN_REG_WR    = 4'd11
    } debug_fn_e;

    localparam logic [7:0] ACK_BYTE_DEF = 8'hA5;
    localparam logic [7:0] ERR_BYTE_DEF = 8'hEE;

    function automatic logic opcode_ok(input logic [7:0] op);
        return (op[7:4] == 4'h0) && (op[3:0] != 4'h0) && (op[3:0] <= 4'd11);
    endfunction

    function automatic logic [3:0] payload_len(input debug_fn_e fn);
        case (fn)
            FN_BR_PT_ADD, FN_BR_PT_RM, FN_MEM_RD, FN_REG_RD: return 4'd4;
            FN_MEM_WR, FN_REG_WR:                            return 4'd8;
            default:                                         return 4'd0;
        endcase
    endfunction

    function automatic logic returns_data(input debug_fn_e fn);
        return (fn == FN_MEM_RD) || (fn == FN_REG_RD) || (fn == FN_STATUS);
    endfunction

endpackage

// File: rtl/reply_serializer.sv
// rtl/reply_serializer.sv - shifts a 1- or 4-byte reply out MSB first over the uart_tx start/busy handshake
module reply_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [31:0] data_i,
    input  logic        four_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_start_o,
    output logic        done_o
);

    typedef enum logic [1:0] {SR_IDLE, SR_SEND, SR_GAP, SR_WAIT} sr_state_e;

    sr_state_e   state_q;
    logic [31:0] shift_q;
    logic [2:0]  rem_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SR_IDLE;
            shift_q    <= 32'h0;
            rem_q      <= 3'd0;
            tx_data_q  <= 8'h0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                SR_IDLE: begin
                    if (load_i) begin
                        shift_q <= data_i;
                        rem_q   <= four_i ? 3'd4 : 3'd1;
                        state_q <= SR_SEND;
                    end
                end
                SR_SEND: begin
                    if (!tx_busy_i) begin
                        tx_data_q  <= shift_q[31:24];
                        shift_q    <= {shift_q[23:0], 8'h0};
                        rem_q      <= rem_q - 3'd1;
                        tx_start_q <= 1'b1;
                        state_q    <= SR_GAP;
                    end
                end
                // uart_tx raises busy the cycle after start; skip that cycle before polling
                SR_GAP: state_q <= SR_WAIT;
                SR_WAIT: begin
                    if (!tx_busy_i) begin
                        if (rem_q == 3'd0) begin
                            done_q  <= 1'b1;
                            state_q <= SR_IDLE;
                        end else begin
                            state_q <= SR_SEND;
                        end
                    end
                end
                default: state_q <= SR_IDLE;
            endcase
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_start_o = tx_start_q;
    assign done_o     = done_q;

endmodule

// File: rtl/serial_cmd_decoder.sv
// rtl/serial_cmd_decoder.sv - frames UART bytes into debug commands and returns ACK/ERR/read-data replies
module serial_cmd_decoder
    import debug_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] ACK_BYTE       = ACK_BYTE_DEF,
    parameter logic [7:0] ERR_BYTE       = ERR_BYTE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic        ctrlr_busy,
    input  logic [31:0] d_rd,
    output logic [3:0]  debug_fn,
    output logic [31:0] addr,
    output logic [31:0] d_in,
    output logic        out_valid,
    output logic        rx_drop,
    output logic        frame_err
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]  TO_MAX  = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_PAYLOAD, ST_DISPATCH, ST_WAIT_CTRL, ST_ERR_REPLY, ST_REPLY
    } state_e;

    state_e        state_q;
    debug_fn_e     fn_q;
    logic [31:0]   addr_q;
    logic [31:0]   d_in_q;
    logic [2:0]    byte_cnt_q;
    logic [CW-1:0] idle_cnt_q;
    logic          out_valid_q;
    logic          rx_drop_q;
    logic          frame_err_q;
    logic          ser_load_q;
    logic [31:0]   ser_data_q;
    logic          ser_four_q;
    logic          ser_done;
    logic          busy_state;

    assign busy_state = (state_q != ST_IDLE) && (state_q != ST_PAYLOAD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fn_q        <= FN_NONE;
            addr_q      <= 32'h0;
            d_in_q      <= 32'h0;
            byte_cnt_q  <= 3'd0;
            idle_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            rx_drop_q   <= 1'b0;
            frame_err_q <= 1'b0;
            ser_load_q  <= 1'b0;
            ser_data_q  <= 32'h0;
            ser_four_q  <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            rx_drop_q   <= rx_valid && busy_state;
            frame_err_q <= 1'b0;
            ser_load_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_valid) begin
                        addr_q     <= 32'h0;
                        d_in_q     <= 32'h0;
                        byte_cnt_q <= 3'd0;
                        idle_cnt_q <= '0;
                        if (!opcode_ok(rx_data)) begin
                            fn_q        <= FN_NONE;
                            frame_err_q <= 1'b1;
                            state_q     <= ST_ERR_REPLY;
                        end else begin
                            fn_q    <= debug_fn_e'(rx_data[3:0]);
                            state_q <= (payload_len(debug_fn_e'(rx_data[3:0])) == 4'd0)
                                       ? ST_DISPATCH : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // a byte on the timeout cycle is still accepted
                    if (rx_valid) begin
                        idle_cnt_q <= '0;
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        if (!byte_cnt_q[2]) addr_q <= {addr_q[23:0], rx_data};
                        else                d_in_q <= {d_in_q[23:0], rx_data};
                        if ({1'b0, byte_cnt_q} == payload_len(fn_q) - 4'd1)
                            state_q <= ST_DISPATCH;
                    end else if (idle_cnt_q == TO_LAST) begin
                        idle_cnt_q  <= TO_MAX;
                        frame_err_q <= 1'b1;
                        state_q     <= ST_ERR_REPLY;
                    end else if (idle_cnt_q != TO_MAX) begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
                end
                ST_DISPATCH: begin
                    if (!ctrlr_busy) begin
                        out_valid_q <= 1'b1;
                        state_q     <= ST_WAIT_CTRL;
                    end
                end
                ST_WAIT_CTRL: begin
                    if (!ctrlr_busy) begin
                        ser_load_q <= 1'b1;
                        if (returns_data(fn_q)) begin
                            ser_data_q <= d_rd;
                            ser_four_q <= 1'b1;
                        end else begin
                            ser_data_q <= {ACK_BYTE, 24'h0};
                            ser_four_q <= 1'b0;
                        end
                        state_q <= ST_REPLY;
                    end
                end
                ST_ERR_REPLY: begin
                    ser_load_q <= 1'b1;
                    ser_data_q <= {ERR_BYTE, 24'h0};
                    ser_four_q <= 1'b0;
                    state_q    <= ST_REPLY;
                end
                ST_REPLY: begin
                    if (ser_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    reply_serializer u_reply (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (ser_load_q),
        .data_i     (ser_data_q),
        .four_i     (ser_four_q),
        .tx_busy_i  (tx_busy),
        .tx_data_o  (tx_data),
        .tx_start_o (tx_start),
        .done_o     (ser_done)
    );

    assign debug_fn  = fn_q;
    assign addr      = addr_q;
    assign d_in      = d_in_q;
    assign out_valid = out_valid_q;
    assign rx_drop   = rx_drop_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_cmd_decoder.sv
// tb/tb_serial_cmd_decoder.sv - directed self-checking bench for serial_cmd_decoder
module tb_serial_cmd_decoder;

    localparam int T = 40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        ctrlr_busy = 1'b0;
    logic [31:0] d_rd = 32'h0;
    logic [3:0]  debug_fn;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic        out_valid;
    logic        rx_drop;
    logic        frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    int fe_cnt   = 0;
    int drop_cnt = 0;
    int txs_cnt  = 0;
    logic [7:0] tx_log[$];

    serial_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .ctrlr_busy (ctrlr_busy),
        .d_rd       (d_rd),
        .debug_fn   (debug_fn),
        .addr       (addr),
        .d_in       (d_in),
        .out_valid  (out_valid),
        .rx_drop    (rx_drop),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) ov_cnt   <= ov_cnt + 1;
        if (frame_err) fe_cnt   <= fe_cnt + 1;
        if (rx_drop)   drop_cnt <= drop_cnt + 1;
        if (tx_start) begin
            txs_cnt <= txs_cnt + 1;
            tx_log.push_back(tx_data);
        end
    end

    // uart_tx model: busy rises the cycle after tx_start and stays up three cycles
    initial begin
        int bcnt;
        bcnt    = 0;
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_start) begin
                tx_busy = 1'b1;
                bcnt    = 3;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_byte(b);
        tick(1);
    endtask

    task automatic wait_out_valid(input string tag);
        int i;
        for (i = 0; i < 100 && !out_valid; i++) tick(1);
        check(tag, 32'(i < 100), 32'd1);
    endtask

    task automatic wait_tx(input string tag, input int n);
        int i;
        for (i = 0; i < 300 && tx_log.size() < n; i++) tick(1);
        check(tag, 32'(i < 300), 32'd1);
        for (i = 0; i < 50 && tx_busy; i++) tick(1);
        tick(4);
    endtask

    initial begin
        int base, ov0, fe0, dr0, i;
        logic [7:0] op_tbl [4];

        tick(2);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_debug_fn", 32'(debug_fn), 32'd0);
        check("rst_addr", addr, 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        reset = 1'b1;
        tick(2);

        // PAUSE while the controller is busy for three cycles
        base = tx_log.size(); ov0 = ov_cnt;
        ctrlr_busy = 1'b1;
        send_byte(8'h01);
        tick(3);
        check("t1_no_ov_busy", 32'(ov_cnt - ov0), 32'd0);
        ctrlr_busy = 1'b0;
        wait_out_valid("t1_ov_seen");
        check("t1_fn", 32'(debug_fn), 32'd1);
        check("t1_addr", addr, 32'd0);
        check("t1_din", d_in, 32'd0);
        wait_tx("t1_tx_wait", base + 1);
        check("t1_single_ov", 32'(ov_cnt - ov0), 32'd1);
        check("t1_ack", 32'(tx_log[base]), 32'hA5);

        // MEM_WR with exact dispatch latency
        base = tx_log.size();
        op_tbl[0] = 8'h00; op_tbl[1] = 8'h00; op_tbl[2] = 8'h10; op_tbl[3] = 8'h00;
        send_byte(8'h09);
        for (int k = 0; k < 4; k++) send_byte(op_tbl[k]);
        op_tbl[0] = 8'hDE; op_tbl[1] = 8'hAD; op_tbl[2] = 8'hBE;
        for (int k = 0; k < 3; k++) send_byte(op_tbl[k]);
        drive_byte(8'hEF);
        check("t2_ov_not_early", 32'(out_valid), 32'd0);
        tick(1);
        check("t2_ov_latency", 32'(out_valid), 32'd1);
        check("t2_fn", 32'(debug_fn), 32'd9);
        check("t2_addr", addr, 32'h00001000);
        check("t2_din", d_in, 32'hDEADBEEF);
        ctrlr_busy = 1'b1;
        tick(2);
        ctrlr_busy = 1'b0;
        wait_tx("t2_tx_wait", base + 1);
        check("t2_ack", 32'(tx_log[base]), 32'hA5);
        check("t2_addr_hold", addr, 32'h00001000);

        // MEM_RD returning four bytes MSB first
        base = tx_log.size();
        send_byte(8'h08);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        drive_byte(8'h04);
        tick(1);
        check("t3_ov", 32'(out_valid), 32'd1);
        ctrlr_busy = 1'b1;
        tick(3);
        d_rd = 32'h12345678;
        ctrlr_busy = 1'b0;
        tick(1);
        d_rd = 32'h0;
        wait_tx("t3_tx_wait", base + 4);
        check("t3_addr", addr, 32'h00000004);
        check("t3_tx_count", 32'(tx_log.size() - base), 32'd4);
        check("t3_b0", 32'(tx_log[base]),     32'h12);
        check("t3_b1", 32'(tx_log[base + 1]), 32'h34);
        check("t3_b2", 32'(tx_log[base + 2]), 32'h56);
        check("t3_b3", 32'(tx_log[base + 3]), 32'h78);

        // bad opcodes: fn above REG_WR, then nonzero upper nibble
        base = tx_log.size(); ov0 = ov_cnt; fe0 = fe_cnt;
        send_byte(8'h0C);
        wait_tx("t4a_tx_wait", base + 1);
        check("t4a_fe", 32'(fe_cnt - fe0), 32'd1);
        check("t4a_err", 32'(tx_log[base]), 32'hEE);
        send_byte(8'h31);
        wait_tx("t4b_tx_wait", base + 2);
        check("t4b_fe", 32'(fe_cnt - fe0), 32'd2);
        check("t4b_err", 32'(tx_log[base + 1]), 32'hEE);
        check("t4_no_ov", 32'(ov_cnt - ov0), 32'd0);

        // inter-byte timeout inside a partial frame
        base = tx_log.size(); ov0 = ov_cnt;
        send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
        for (i = 0; i < 3 * T && !frame_err; i++) tick(1);
        check("t5_fe_seen", 32'(frame_err), 32'd1);
        check("t5_fe_timing", 32'((i >= T - 2) && (i <= T + 1)), 32'd1);
        wait_tx("t5_tx_wait", base + 1);
        check("t5_err", 32'(tx_log[base]), 32'hEE);
        check("t5_no_ov", 32'(ov_cnt - ov0), 32'd0);
        send_byte(8'h01);
        wait_out_valid("t5_pause_ov");
        check("t5_pause_fn", 32'(debug_fn), 32'd1);
        wait_tx("t5_ack_wait", base + 2);
        check("t5_ack", 32'(tx_log[base + 1]), 32'hA5);

        // dispatch held off by a busy controller, byte dropped while waiting
        ov0 = ov_cnt; dr0 = drop_cnt; base = tx_log.size();
        ctrlr_busy = 1'b1;
        send_byte(8'h02);
        send_byte(8'h07);
        tick(8);
        check("t6_hold_no_ov", 32'(ov_cnt - ov0), 32'd0);
        check("t6_drop_dispatch", 32'(drop_cnt - dr0), 32'd1);
        ctrlr_busy = 1'b0;
        wait_out_valid("t6_ov_seen");
        check("t6_fn", 32'(debug_fn), 32'd2);
        wait_tx("t6_ack_wait", base + 1);
        check("t6_ack", 32'(tx_log[base]), 32'hA5);

        // REG_RD reply interrupted by reset after the first byte
        base = tx_log.size(); dr0 = drop_cnt;
        d_rd = 32'hCAFEF00D;
        send_byte(8'h0A);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
        for (i = 0; i < 200 && tx_log.size() < base + 1; i++) tick(1);
        check("t6r_first_byte_seen", 32'(i < 200), 32'd1);
        send_byte(8'h55);
        check("t6r_drop_reply", 32'(drop_cnt - dr0), 32'd1);
        reset = 1'b0;
        #2;
        check("t6r_tx_start", 32'(tx_start), 32'd0);
        check("t6r_out_valid", 32'(out_valid), 32'd0);
        check("t6r_addr", addr, 32'd0);
        check("t6r_fn", 32'(debug_fn), 32'd0);
        check("t6r_tx_data", 32'(tx_data), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(60);
        check("t6r_first_byte", 32'(tx_log[base]), 32'hCA);
        check("t6r_no_more_tx", 32'(tx_log.size() - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
